dac_pwc_pacer: RTL and testbench

//  Clocked DAC behavioural stage that sits directly upstream of the real-to-pwl converter.
//  - Accepts N-bit codes over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
//  - Drives a piecewise-constant real output from the buffered codes.
//  - Paces output changes to at most one per HOLD_CYC clocks. This guarantees the

---
 rtl/dac_pwc_pacer.sv | 98 +++++++++
 tb/tb_dac_pwc_pacer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dac_pwc_pacer.sv
// Paced DAC stage: a small code FIFO that drives a piecewise-constant real output.
// Output updates are spaced at least HOLD_CYC clocks apart.
module dac_pwc_pacer #(
    parameter int  N        = 8,
    parameter int  DEPTH    = 4,
    parameter int  HOLD_CYC = 4,
    parameter int  SIGNED   = 0,
    parameter real VREF     = 1.0,
    parameter real VOFS     = 0.0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic [N-1:0]                 in_code,
    input  logic                         in_valid,
    output logic                         in_ready,
    output real                          out,
    output logic                         out_upd,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int  PTR_W = $clog2(DEPTH);
    localparam int  LVL_W = $clog2(DEPTH + 1);
    localparam int  HC_W  = $clog2(HOLD_CYC + 1);
    localparam real SCALE = 2.0 ** N;

    logic [N-1:0]     mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [HC_W-1:0]  hcnt_reg;
    real              out_reg;
    logic             out_upd_reg;

    logic             push;
    logic             pop;
    logic [N-1:0]     head_code;
    real              head_val;
    real              out_next;

    // Full is judged from the occupancy count, so a same-cycle pop never frees a slot early.
    assign in_ready = rstn & en & (level_reg < LVL_W'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = en & (level_reg != '0) & (hcnt_reg == '0);

    always_comb begin
        head_code = mem_reg[rd_ptr_reg];
        head_val  = 0.0;
        if (SIGNED != 0) begin
            head_val = real'($signed(head_code));
        end else begin
            head_val = real'(head_code);
        end
        out_next = VOFS + VREF * head_val / SCALE;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= in_code;
        end
    end

    // Deasserting en behaves exactly like reset: queued codes are dropped, never emitted.
    always_ff @(posedge clk) begin
        if (!rstn || !en) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            level_reg   <= '0;
            hcnt_reg    <= '0;
            out_reg     <= 0.0;
            out_upd_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
                out_reg     <= out_next;
                hcnt_reg    <= HC_W'(HOLD_CYC - 1);
                out_upd_reg <= 1'b1;
            end else begin
                out_upd_reg <= 1'b0;
                if (hcnt_reg != '0) begin
                    hcnt_reg <= hcnt_reg - HC_W'(1);
                end
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign out     = out_reg;
    assign out_upd = out_upd_reg;
    assign level   = level_reg;

endmodule

// File: tb/tb_dac_pwc_pacer.sv
// Scoreboard bench for dac_pwc_pacer: instance a is unsigned/HOLD 4, instance b is
// signed/HOLD 8 with a 0.5 offset.
module tb_dac_pwc_pacer;
    logic       clk = 1'b0;
    logic       rstn;
    logic       a_en, a_valid, a_ready, a_upd;
    logic [7:0] a_code;
    logic [2:0] a_level;
    real        a_out;
    logic       b_en, b_valid, b_ready, b_upd;
    logic [7:0] b_code;
    logic [2:0] b_level;
    real        b_out;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    real sb_a[$];
    real sb_b[$];
    int  a_upd_cyc[$];
    int  b_upd_cnt = 0;
    int  a_lvl_max = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_pwc_pacer #(.N(8), .DEPTH(4), .HOLD_CYC(4), .SIGNED(0), .VREF(1.0), .VOFS(0.0)) u_a (
        .clk(clk), .rstn(rstn), .en(a_en), .in_code(a_code), .in_valid(a_valid),
        .in_ready(a_ready), .out(a_out), .out_upd(a_upd), .level(a_level)
    );

    dac_pwc_pacer #(.N(8), .DEPTH(4), .HOLD_CYC(8), .SIGNED(1), .VREF(1.0), .VOFS(0.5)) u_b (
        .clk(clk), .rstn(rstn), .en(b_en), .in_code(b_code), .in_valid(b_valid),
        .in_ready(b_ready), .out(b_out), .out_upd(b_upd), .level(b_level)
    );

    task automatic check(input string tag, input real got, input real exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %g expected %g", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Holds in_valid until the DUT accepts; the expected output goes to the scoreboard on acceptance.
    task automatic push(input bit sel, input logic [7:0] c, output int stalls);
        bit acc = 1'b0;
        stalls = 0;
        if (!sel) begin a_code = c; a_valid = 1'b1; end
        else      begin b_code = c; b_valid = 1'b1; end
        while (!acc && stalls <= 50) begin
            #1;
            if ((sel ? b_ready : a_ready) === 1'b1) begin
                acc = 1'b1;
                if (!sel) sb_a.push_back(real'(c) / 256.0);
                else      sb_b.push_back(0.5 + real'($signed(c)) / 256.0);
            end else begin
                stalls++;
                check(sel ? "b_full_on_stall" : "a_full_on_stall",
                      real'(sel ? b_level : a_level), 4.0);
            end
            @(negedge clk);
        end
        if (!acc) check("push_timeout", real'(acc), 1.0);
        if (!sel) a_valid = 1'b0;
        else      b_valid = 1'b0;
    endtask

    initial begin
        real e;
        forever begin
            @(negedge clk);
            if (int'(a_level) > a_lvl_max) a_lvl_max = int'(a_level);
            if (a_upd === 1'b1) begin
                a_upd_cyc.push_back(cyc);
                if (sb_a.size() == 0) begin
                    check("a_spurious_upd", real'(a_upd), 0.0);
                end else begin
                    e = sb_a.pop_front();
                    $display("a: update cyc=%0d out=%g", cyc, a_out);
                    check("a_out", a_out, e);
                end
            end
            if (b_upd === 1'b1) begin
                b_upd_cnt++;
                if (sb_b.size() == 0) begin
                    check("b_spurious_upd", real'(b_upd), 0.0);
                end else begin
                    e = sb_b.pop_front();
                    $display("b: update cyc=%0d out=%g", cyc, b_out);
                    check("b_out", b_out, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int tot;
        int k;
        rstn = 1'b0; a_en = 1'b1; b_en = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; a_code = 8'd5; b_code = 8'd5;

        // reset holds everything idle even with in_valid asserted
        repeat (3) begin
            tick();
            check("t1_out", a_out, 0.0);
            check("t1_level", real'(a_level), 0.0);
            check("t1_ready", real'(a_ready), 0.0);
            check("t1_upd", real'(a_upd), 0.0);
            check("t1_b_ready", real'(b_ready), 0.0);
        end
        a_valid = 1'b0; b_valid = 1'b0; rstn = 1'b1;
        tick();

        // single-cycle latency and conversion
        push(1'b0, 8'd128, st);
        check("t2_upd_early", real'(a_upd), 0.0);
        check("t2_level", real'(a_level), 1.0);
        tick();
        check("t2_upd", real'(a_upd), 1.0);
        check("t2_out", a_out, 0.5);
        tick();
        check("t2_pulse_end", real'(a_upd), 0.0);
        repeat (4) tick();

        // pacing and order
        a_upd_cyc.delete();
        a_lvl_max = 0;
        push(1'b0, 8'd10, st);
        k = cyc;
        push(1'b0, 8'd20, st);
        push(1'b0, 8'd30, st);
        check("t3_level", real'(a_level), 2.0);
        repeat (10) tick();
        check("t3_n_upd", real'(a_upd_cyc.size()), 3.0);
        for (int i = 0; i < 3; i++) begin
            check("t3_upd_cycle", real'(i < a_upd_cyc.size() ? a_upd_cyc[i] - k : -1),
                  real'(1 + 4 * i));
        end
        check("t3_peak", real'(a_lvl_max), 2.0);
        repeat (4) tick();

        // signed conversion with offset
        push(1'b1, 8'h80, st);
        push(1'b1, 8'h7F, st);
        repeat (20) tick();

        // fill to full, stall, wrap the pointers
        tot = 0;
        for (int i = 1; i <= 6; i++) begin
            push(1'b1, 8'(i * 37), st);
            tot += st;
        end
        check("t4_stalls", real'(tot), 5.0);
        repeat (45) tick();
        check("t4_b_upd_cnt", real'(b_upd_cnt), 8.0);
        check("t4_sb_b_empty", real'(sb_b.size()), 0.0);

        // flush via en
        push(1'b0, 8'd5, st);
        push(1'b0, 8'd6, st);
        push(1'b0, 8'd7, st);
        push(1'b0, 8'd8, st);
        check("t6_level_pre", real'(a_level), 3.0);
        sb_a.delete();
        a_en = 1'b0;
        #1;
        check("t6_ready_en0", real'(a_ready), 0.0);
        tick();
        check("t6_out_flushed", a_out, 0.0);
        check("t6_level_flushed", real'(a_level), 0.0);
        check("t6_upd_flushed", real'(a_upd), 0.0);
        a_en = 1'b1;
        push(1'b0, 8'd64, st);
        tick();
        check("t6_upd", real'(a_upd), 1.0);
        check("t6_out", a_out, 0.25);
        repeat (10) tick();
        check("t6_sb_a_empty", real'(sb_a.size()), 0.0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
